// File: rtl/mac_grp_ts_pkg.sv
// Shared register map, control bits and queue entry layout for the MAC group
// PTP timestamp capture queue.
package mac_grp_ts_pkg;

    localparam int REG_STATUS     = 0;
    localparam int REG_HEAD_INFO  = 1;
    localparam int REG_HEAD_TS_HI = 2;
    localparam int REG_HEAD_TS_LO = 3;
    localparam int REG_POP        = 4;
    localparam int REG_DROP_CNT   = 5;
    localparam int REG_CTRL       = 6;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    localparam int ENTRY_PORT_W  = 8;
    localparam int ENTRY_TS_W    = 64;
    localparam int INFO_PORT_LSB = 0;
    localparam int INFO_DIR_BIT  = 8;
    localparam int STATUS_NE_BIT = 31;

    typedef struct packed {
        logic                    dir;
        logic [ENTRY_PORT_W-1:0] port;
        logic [ENTRY_TS_W-1:0]   ts;
    } ts_entry_t;

endpackage

// File: rtl/mac_grp_ts_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer one past the winner.
module mac_grp_ts_rr_arb #(
    parameter int N = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                clear_i,
    input  logic                                en_i,
    input  logic [N-1:0]                        req_i,
    output logic [N-1:0]                        gnt_o,
    output logic                                gnt_valid_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        ptr_d       = ptr_q;
        idx         = 0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!gnt_valid_o && req_i[idx]) begin
                    gnt_valid_o = 1'b1;
                    gnt_o[idx]  = 1'b1;
                    gnt_idx_o   = IW'(idx);
                    ptr_d       = (idx == N - 1) ? '0 : IW'(idx + 1);
                end
            end
        end
        if (clear_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mac_grp_ts_fifo.sv
// Multi-port PTP timestamp capture queue: per-source hold/pending buffers,
// round-robin merge into one FIFO, drained through the register interface.
module mac_grp_ts_fifo
    import mac_grp_ts_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int COUNTER_WIDTH   = 64,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int REG_ADDR_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      valid_rx,
    input  logic [NUM_PORTS-1:0]      valid_tx,
    input  logic [COUNTER_WIDTH-1:0]  counter_val,
    input  logic                      ts_reg_req,
    input  logic                      ts_reg_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0] ts_reg_addr,
    input  logic [31:0]               ts_reg_wr_data,
    output logic [31:0]               ts_reg_rd_data,
    output logic                      ts_reg_ack,
    output logic                      ts_avail
);
    localparam int NSRC  = 2 * NUM_PORTS;
    localparam int IW    = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_W = FIFO_DEPTH_BITS + 1;

    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = FIFO_DEPTH_BITS'(1);
    localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]           CNT_FULL = CNT_W'(DEPTH);

    ts_entry_t                  mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [COUNTER_WIDTH-1:0]   hold_q [NSRC];
    logic [COUNTER_WIDTH-1:0]   hold_d [NSRC];
    logic [NSRC-1:0]            pend_q, pend_d;
    logic [31:0]                drop_q, drop_d;
    logic                       cap_en_q, cap_en_d;
    logic                       ack_q;
    logic [31:0]                rd_data_q;
    logic                       wr_cmd_q;
    logic [REG_ADDR_WIDTH-1:0]  wr_addr_q;
    logic [1:0]                 wr_data_q;

    logic            full, empty, push, do_ctrl, do_flush, do_pop, do_drop_clr;
    logic [NSRC-1:0] pulse, gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;
    logic [31:0]     drop_inc, rd_val;
    logic [32:0]     drop_sum;
    ts_entry_t       push_entry, head;
    logic            unused_wr_data;

    assign unused_wr_data = ^ts_reg_wr_data[31:2];

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Register writes act in the ack cycle, one cycle after the request.
    assign do_ctrl     = wr_cmd_q && (int'(wr_addr_q) == REG_CTRL);
    assign do_flush    = do_ctrl && wr_data_q[CTRL_FLUSH_BIT];
    assign do_pop      = wr_cmd_q && (int'(wr_addr_q) == REG_POP) && !empty;
    assign do_drop_clr = wr_cmd_q && (int'(wr_addr_q) == REG_DROP_CNT);
    assign cap_en_d    = do_ctrl ? wr_data_q[CTRL_EN_BIT] : cap_en_q;

    assign pulse = {valid_tx, valid_rx} & {NSRC{cap_en_q && !do_flush}};

    mac_grp_ts_rr_arb #(.N(NSRC)) u_arb (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (do_flush),
        .en_i       (!full && !do_flush),
        .req_i      (pend_q),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    assign push = gnt_valid;

    always_comb begin
        int gi;
        gi                               = int'(gnt_idx);
        push_entry                       = '0;
        push_entry.dir                   = (gi >= NUM_PORTS) ? DIR_TX : DIR_RX;
        push_entry.port                  = ENTRY_PORT_W'((gi >= NUM_PORTS) ? gi - NUM_PORTS : gi);
        push_entry.ts[COUNTER_WIDTH-1:0] = hold_q[gnt_idx];
    end

    // A granted slot can take a new pulse in the same cycle; otherwise a
    // pulse on a still-pending slot is lost and counted.
    always_comb begin
        drop_inc = '0;
        pend_d   = pend_q & ~gnt;
        for (int i = 0; i < NSRC; i++) begin
            hold_d[i] = hold_q[i];
            if (pulse[i]) begin
                if (pend_q[i] && !gnt[i]) begin
                    drop_inc = drop_inc + 32'd1;
                end else begin
                    pend_d[i] = 1'b1;
                    hold_d[i] = counter_val;
                end
            end
        end
        if (do_flush) begin
            pend_d = '0;
        end
        drop_sum = {1'b0, drop_q} + {1'b0, drop_inc};
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
        if (do_drop_clr) begin
            drop_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        head   = mem_q[rd_ptr_q];
        rd_val = '0;
        case (int'(ts_reg_addr))
            REG_STATUS: begin
                rd_val[CNT_W-1:0]    = count_q;
                rd_val[STATUS_NE_BIT] = !empty;
            end
            REG_HEAD_INFO: begin
                if (!empty) begin
                    rd_val[INFO_PORT_LSB +: ENTRY_PORT_W] = head.port;
                    rd_val[INFO_DIR_BIT]                  = head.dir;
                end
            end
            REG_HEAD_TS_HI: if (!empty) rd_val = head.ts[ENTRY_TS_W-1:32];
            REG_HEAD_TS_LO: if (!empty) rd_val = head.ts[31:0];
            REG_DROP_CNT:   rd_val = drop_q;
            REG_CTRL:       rd_val[CTRL_EN_BIT] = cap_en_q;
            default:        rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            drop_q    <= '0;
            cap_en_q  <= 1'b1;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
            wr_cmd_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            cap_en_q  <= cap_en_d;
            ack_q     <= ts_reg_req;
            rd_data_q <= (ts_reg_req && ts_reg_rd_wr_L) ? rd_val : '0;
            wr_cmd_q  <= ts_reg_req && !ts_reg_rd_wr_L;
            wr_addr_q <= ts_reg_addr;
            wr_data_q <= ts_reg_wr_data[1:0];
            for (int i = 0; i < NSRC; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign ts_reg_ack     = ack_q;
    assign ts_reg_rd_data = rd_data_q;
    assign ts_avail       = !empty;

endmodule

// File: tb/tb_mac_grp_ts_fifo.sv
// Directed bench for mac_grp_ts_fifo: a table of register/pulse operations
// with hand-computed read values, then hand-written full/flush/reset sequences.
module tb_mac_grp_ts_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  valid_rx;
    logic [3:0]  valid_tx;
    logic [63:0] counter_val;
    logic        ts_reg_req;
    logic        ts_reg_rd_wr_L;
    logic [2:0]  ts_reg_addr;
    logic [31:0] ts_reg_wr_data;
    logic [31:0] ts_reg_rd_data;
    logic        ts_reg_ack;
    logic        ts_avail;

    int vecCount  = 0;
    int missCount = 0;

    typedef enum logic [2:0] {OP_PULSE, OP_IDLE, OP_RD, OP_WR, OP_AVAIL} op_e;

    typedef struct packed {
        op_e         op;
        logic [3:0]  rx;
        logic [3:0]  tx;
        logic [63:0] cnt;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mac_grp_ts_fifo #(
        .NUM_PORTS      (4),
        .COUNTER_WIDTH  (64),
        .FIFO_DEPTH_BITS(4),
        .REG_ADDR_WIDTH (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_rx      (valid_rx),
        .valid_tx      (valid_tx),
        .counter_val   (counter_val),
        .ts_reg_req    (ts_reg_req),
        .ts_reg_rd_wr_L(ts_reg_rd_wr_L),
        .ts_reg_addr   (ts_reg_addr),
        .ts_reg_wr_data(ts_reg_wr_data),
        .ts_reg_rd_data(ts_reg_rd_data),
        .ts_reg_ack    (ts_reg_ack),
        .ts_avail      (ts_avail)
    );

    function automatic void addV(op_e op, logic [3:0] rx, logic [3:0] tx, logic [63:0] cnt,
                                 logic [2:0] addr, logic [31:0] data, logic [31:0] exp);
        vec_t v;
        v.op = op; v.rx = rx; v.tx = tx; v.cnt = cnt;
        v.addr = addr; v.data = data; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic void pl(logic [3:0] rx, logic [3:0] tx, logic [63:0] c);
        addV(OP_PULSE, rx, tx, c, 3'd0, 32'd0, 32'd0);
    endfunction
    function automatic void idl(int n);
        addV(OP_IDLE, 4'd0, 4'd0, 64'd0, 3'd0, 32'(n), 32'd0);
    endfunction
    function automatic void rd(logic [2:0] a, logic [31:0] e);
        addV(OP_RD, 4'd0, 4'd0, 64'd0, a, 32'd0, e);
    endfunction
    function automatic void wr(logic [2:0] a, logic [31:0] d);
        addV(OP_WR, 4'd0, 4'd0, 64'd0, a, d, 32'd0);
    endfunction
    function automatic void av(logic e);
        addV(OP_AVAIL, 4'd0, 4'd0, 64'd0, 3'd0, 32'd0, {31'd0, e});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] rx, input logic [3:0] tx, input logic [63:0] c);
        valid_rx    = rx;
        valid_tx    = tx;
        counter_val = c;
        tick();
        valid_rx = '0;
        valid_tx = '0;
    endtask

    task automatic regRead(input logic [2:0] a, output logic [31:0] d);
        ts_reg_req     = 1'b1;
        ts_reg_rd_wr_L = 1'b1;
        ts_reg_addr    = a;
        tick();
        ts_reg_req = 1'b0;
        checkOutput($sformatf("rd ack a%0d", a), {31'd0, ts_reg_ack}, 32'd1);
        d = ts_reg_rd_data;
        tick();
    endtask

    task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
        ts_reg_req     = 1'b1;
        ts_reg_rd_wr_L = 1'b0;
        ts_reg_addr    = a;
        ts_reg_wr_data = d;
        tick();
        ts_reg_req = 1'b0;
        checkOutput($sformatf("wr ack a%0d", a), {31'd0, ts_reg_ack}, 32'd1);
        tick();
    endtask

    task automatic readCheck(input string name, input logic [2:0] a, input logic [31:0] e);
        logic [31:0] d;
        regRead(a, d);
        checkOutput(name, d, e);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] d;
        case (v.op)
            OP_PULSE: pulse(v.rx, v.tx, v.cnt);
            OP_IDLE:  repeat (int'(v.data)) tick();
            OP_RD: begin
                regRead(v.addr, d);
                checkOutput($sformatf("vec%0d rd a%0d", idx, v.addr), d, v.exp);
            end
            OP_WR:    regWrite(v.addr, v.data);
            default:  checkOutput($sformatf("vec%0d ts_avail", idx), {31'd0, ts_avail}, v.exp);
        endcase
    endtask

    initial begin
        reset          = 1'b1;
        valid_rx       = '0;
        valid_tx       = '0;
        counter_val    = '0;
        ts_reg_req     = 1'b0;
        ts_reg_rd_wr_L = 1'b1;
        ts_reg_addr    = '0;
        ts_reg_wr_data = '0;

        // Single RX capture, latency to visibility, pop.
        pl(4'b0100, 4'b0000, 64'h0000_0001_0000_0010); idl(1); av(1'b1);
        rd(3'd0, 32'h8000_0001); rd(3'd1, 32'h0000_0002);
        rd(3'd2, 32'h0000_0001); rd(3'd3, 32'h0000_0010);
        rd(3'd4, 32'h0); rd(3'd7, 32'h0);
        wr(3'd4, 32'h0); rd(3'd0, 32'h0); av(1'b0); rd(3'd1, 32'h0);
        // Flush re-homes the pointer so the next burst drains from rx0.
        wr(3'd6, 32'h3); rd(3'd6, 32'h1);
        pl(4'hF, 4'hF, 64'h55); idl(8);
        rd(3'd0, 32'h8000_0008); rd(3'd5, 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(3'd1, (k < 4) ? 32'(k) : 32'h100 + 32'(k - 4));
            rd(3'd2, 32'h0); rd(3'd3, 32'h55); wr(3'd4, 32'h0);
        end
        rd(3'd0, 32'h0);
        // Back-to-back pulses on one source: grant and re-capture, no drop.
        pl(4'b0010, 4'b0000, 64'h200); pl(4'b0010, 4'b0000, 64'h201); idl(2);
        rd(3'd0, 32'h8000_0002);
        rd(3'd1, 32'h1); rd(3'd3, 32'h200); wr(3'd4, 32'h0);
        rd(3'd1, 32'h1); rd(3'd3, 32'h201); wr(3'd4, 32'h0);
        rd(3'd0, 32'h0); rd(3'd5, 32'h0);

        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset ack", {31'd0, ts_reg_ack}, 32'd0);
        checkOutput("reset rd_data", ts_reg_rd_data, 32'd0);
        checkOutput("reset avail", {31'd0, ts_avail}, 32'd0);
        readCheck("reset status", 3'd0, 32'h0);
        readCheck("reset ctrl", 3'd6, 32'h1);
        checkOutput("idle rd_data", ts_reg_rd_data, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Full FIFO: pending waits, second pulse on the pending source drops.
        pulse(4'hF, 4'hF, 64'h300); repeat (8) tick();
        pulse(4'hF, 4'hF, 64'h301); repeat (8) tick();
        readCheck("full status", 3'd0, 32'h8000_0010);
        pulse(4'b0001, 4'b0000, 64'hA0); tick();
        pulse(4'b0001, 4'b0000, 64'hA8); tick();
        readCheck("full drop", 3'd5, 32'h1);
        readCheck("full held", 3'd0, 32'h8000_0010);
        regWrite(3'd4, 32'h0);
        repeat (2) tick();
        readCheck("refill status", 3'd0, 32'h8000_0010);
        repeat (15) regWrite(3'd4, 32'h0);
        readCheck("last status", 3'd0, 32'h8000_0001);
        readCheck("last info", 3'd1, 32'h0);
        readCheck("last hi", 3'd2, 32'h0);
        readCheck("last lo", 3'd3, 32'hA0);
        regWrite(3'd6, 32'h3);
        readCheck("flush status", 3'd0, 32'h0);
        readCheck("flush info", 3'd1, 32'h0);
        readCheck("flush drop", 3'd5, 32'h1);

        // Flush with 5 queued and tx1/tx2 pending; pulses in the ack cycle vanish.
        pulse(4'hF, 4'b0111, 64'h400);
        repeat (4) tick();
        ts_reg_req     = 1'b1;
        ts_reg_rd_wr_L = 1'b0;
        ts_reg_addr    = 3'd6;
        ts_reg_wr_data = 32'h3;
        tick();
        ts_reg_req = 1'b0;
        checkOutput("flush2 ack", {31'd0, ts_reg_ack}, 32'd1);
        valid_rx    = 4'b0001;
        valid_tx    = 4'b0010;
        counter_val = 64'h4FF;
        tick();
        valid_rx = '0;
        valid_tx = '0;
        repeat (2) tick();
        readCheck("flush2 status", 3'd0, 32'h0);
        readCheck("flush2 drop", 3'd5, 32'h1);
        checkOutput("flush2 avail", {31'd0, ts_avail}, 32'd0);

        // Reset in the middle of draining a burst.
        pulse(4'hF, 4'hF, 64'h500);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        readCheck("midrst status", 3'd0, 32'h0);
        readCheck("midrst drop", 3'd5, 32'h0);
        readCheck("midrst ctrl", 3'd6, 32'h1);
        checkOutput("midrst avail", {31'd0, ts_avail}, 32'd0);

        // Capture disabled, then re-enabled.
        regWrite(3'd6, 32'h0);
        readCheck("dis ctrl", 3'd6, 32'h0);
        pulse(4'b0000, 4'b1000, 64'h600);
        repeat (3) tick();
        readCheck("dis status", 3'd0, 32'h0);
        readCheck("dis drop", 3'd5, 32'h0);
        regWrite(3'd6, 32'h1);
        pulse(4'b0000, 4'b1000, 64'h601);
        tick();
        readCheck("en info", 3'd1, 32'h103);
        readCheck("en lo", 3'd3, 32'h601);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
